// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore microsequencer for the matrix-multiplier CPU
// Walks IDLE/FETCH/DECODE/EX1/EX2/HALT and decodes per-cycle datapath strobes from state and ir.
module control_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ir,
    input  logic        z,
    output logic        end_op,
    output logic [1:0]  inc,
    output logic [3:0]  alu_mode,
    output logic [3:0]  bus_ld,
    output logic [12:0] write_en,
    output logic [2:0]  clr,
    output logic        dm_wr,
    output logic        im_wr
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EX1    = 3'd3;
    localparam logic [2:0] S_EX2    = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [7:0] OP_LDAC   = 8'h01;
    localparam logic [7:0] OP_STAC   = 8'h02;
    localparam logic [7:0] OP_MVACAR = 8'h03;
    localparam logic [7:0] OP_MVACR  = 8'h04;
    localparam logic [7:0] OP_MVRAC  = 8'h05;
    localparam logic [7:0] OP_ADD    = 8'h06;
    localparam logic [7:0] OP_SUB    = 8'h07;
    localparam logic [7:0] OP_MUL    = 8'h08;
    localparam logic [7:0] OP_INCAC  = 8'h09;
    localparam logic [7:0] OP_DECAC  = 8'h0A;
    localparam logic [7:0] OP_CLAC   = 8'h0B;
    localparam logic [7:0] OP_INCAR  = 8'h0C;
    localparam logic [7:0] OP_JMPNZ  = 8'h0D;
    localparam logic [7:0] OP_LDI    = 8'h0E;
    localparam logic [7:0] OP_END    = 8'hFF;

    localparam logic [3:0] BUS_DM = 4'd1;
    localparam logic [3:0] BUS_IM = 4'd2;
    localparam logic [3:0] BUS_DR = 4'd4;
    localparam logic [3:0] BUS_AC = 4'd5;
    localparam logic [3:0] BUS_R  = 4'd6;

    localparam int WE_AR = 0;
    localparam int WE_PC = 1;
    localparam int WE_IR = 2;
    localparam int WE_DR = 3;
    localparam int WE_AC = 4;
    localparam int WE_R  = 5;

    logic [2:0] state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Only LDAC and STAC need a second execute cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = (ir == OP_END) ? S_HALT : S_EX1;
            S_EX1:    state_d = (ir == OP_LDAC || ir == OP_STAC) ? S_EX2 : S_FETCH;
            S_EX2:    state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        end_op   = 1'b0;
        inc      = 2'b00;
        alu_mode = 4'd0;
        bus_ld   = 4'd0;
        write_en = 13'd0;
        clr      = 3'b000;
        dm_wr    = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus_ld          = BUS_IM;
                write_en[WE_IR] = 1'b1;
                inc[0]          = 1'b1;
            end
            S_EX1: begin
                case (ir)
                    OP_LDAC: begin
                        bus_ld = BUS_DM;  write_en[WE_DR] = 1'b1;
                    end
                    OP_STAC: begin
                        bus_ld = BUS_AC;  write_en[WE_DR] = 1'b1;
                    end
                    OP_MVACAR: begin
                        bus_ld = BUS_AC;  write_en[WE_AR] = 1'b1;
                    end
                    OP_MVACR: begin
                        bus_ld = BUS_AC;  write_en[WE_R] = 1'b1;
                    end
                    OP_MVRAC, OP_ADD, OP_SUB, OP_MUL: begin
                        bus_ld          = BUS_R;
                        alu_mode        = (ir == OP_MVRAC) ? 4'd1 : ir[3:0] - 4'd4;
                        write_en[WE_AC] = 1'b1;
                    end
                    OP_INCAC: begin
                        alu_mode = 4'd5;  write_en[WE_AC] = 1'b1;
                    end
                    OP_DECAC: begin
                        alu_mode = 4'd6;  write_en[WE_AC] = 1'b1;
                    end
                    OP_CLAC:  clr[0] = 1'b1;
                    OP_INCAR: inc[1] = 1'b1;
                    OP_JMPNZ: begin
                        // Taken jump loads PC from the operand; otherwise skip over it.
                        bus_ld = BUS_IM;
                        if (z) inc[0] = 1'b1;
                        else   write_en[WE_PC] = 1'b1;
                    end
                    OP_LDI: begin
                        bus_ld          = BUS_IM;
                        alu_mode        = 4'd1;
                        write_en[WE_AC] = 1'b1;
                        inc[0]          = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EX2: begin
                if (ir == OP_LDAC) begin
                    bus_ld          = BUS_DR;
                    alu_mode        = 4'd1;
                    write_en[WE_AC] = 1'b1;
                end else if (ir == OP_STAC) begin
                    dm_wr = 1'b1;
                end
            end
            S_HALT:  end_op = 1'b1;
            default: ;
        endcase
    end

    assign im_wr = 1'b0;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized bench for control_unit against an instruction-level model
// Expected strobes come from a per-instruction cycle table; inputs are random with random resets.
module tb_control_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ir;
    logic        z;
    logic        end_op;
    logic [1:0]  inc;
    logic [3:0]  alu_mode;
    logic [3:0]  bus_ld;
    logic [12:0] write_en;
    logic [2:0]  clr;
    logic        dm_wr;
    logic        im_wr;

    int checks = 0;
    int failures = 0;

    control_unit dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .z(z),
        .end_op(end_op), .inc(inc), .alu_mode(alu_mode), .bus_ld(bus_ld),
        .write_en(write_en), .clr(clr), .dm_wr(dm_wr), .im_wr(im_wr)
    );

    always #5 clk = ~clk;

    wire [28:0] obs = {end_op, inc, alu_mode, bus_ld, write_en, clr, dm_wr, im_wr};

    task automatic check_eq(input string tag, input logic [28:0] got, input logic [28:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (ir=%h z=%b)", tag, got, exp, ir, z);
        end
    endtask

    // reg = -1 means no register loaded this cycle
    function automatic logic [28:0] pk(input logic e, input logic [1:0] i, input int alu,
                                       input int bus, input int reg_idx, input logic [2:0] c,
                                       input logic dm);
        logic [12:0] we;
        we = (reg_idx < 0) ? 13'd0 : (13'd1 << reg_idx);
        return {e, i, 4'(alu), 4'(bus), we, c, dm, 1'b0};
    endfunction

    // Phases: -1 idle, 0 fetch, 1 decode, 2 execute-1, 3 execute-2, 4 halted.
    function automatic logic [28:0] model_out(input int ph, input logic [7:0] op, input logic zf);
        case (ph)
            0: return pk(1'b0, 2'b01, 0, 2, 2, 3'b000, 1'b0);
            4: return pk(1'b1, 2'b00, 0, 0, -1, 3'b000, 1'b0);
            2: case (op)
                8'h01: return pk(1'b0, 2'b00, 0, 1, 3, 3'b000, 1'b0);
                8'h02: return pk(1'b0, 2'b00, 0, 5, 3, 3'b000, 1'b0);
                8'h03: return pk(1'b0, 2'b00, 0, 5, 0, 3'b000, 1'b0);
                8'h04: return pk(1'b0, 2'b00, 0, 5, 5, 3'b000, 1'b0);
                8'h05: return pk(1'b0, 2'b00, 1, 6, 4, 3'b000, 1'b0);
                8'h06: return pk(1'b0, 2'b00, 2, 6, 4, 3'b000, 1'b0);
                8'h07: return pk(1'b0, 2'b00, 3, 6, 4, 3'b000, 1'b0);
                8'h08: return pk(1'b0, 2'b00, 4, 6, 4, 3'b000, 1'b0);
                8'h09: return pk(1'b0, 2'b00, 5, 0, 4, 3'b000, 1'b0);
                8'h0A: return pk(1'b0, 2'b00, 6, 0, 4, 3'b000, 1'b0);
                8'h0B: return pk(1'b0, 2'b00, 0, 0, -1, 3'b001, 1'b0);
                8'h0C: return pk(1'b0, 2'b10, 0, 0, -1, 3'b000, 1'b0);
                8'h0D: return zf ? pk(1'b0, 2'b01, 0, 2, -1, 3'b000, 1'b0)
                                 : pk(1'b0, 2'b00, 0, 2, 1, 3'b000, 1'b0);
                8'h0E: return pk(1'b0, 2'b01, 1, 2, 4, 3'b000, 1'b0);
                default: return 29'd0;
            endcase
            3: case (op)
                8'h01: return pk(1'b0, 2'b00, 1, 4, 4, 3'b000, 1'b0);
                8'h02: return pk(1'b0, 2'b00, 0, 0, -1, 3'b000, 1'b1);
                default: return 29'd0;
            endcase
            default: return 29'd0;
        endcase
    endfunction

    logic [7:0] directed [18] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
                                  8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0D, 8'h0E, 8'h00, 8'h77, 8'hFF};
    string ph_name [6] = '{"idle", "fetch", "decode", "ex1", "ex2", "halt"};

    initial begin
        int ph;
        int halt_cnt;
        int didx;
        bit did_ldac_rst;
        bit do_rst;
        logic [7:0] op;

        ph = -1; halt_cnt = 0; didx = 0; did_ldac_rst = 0; op = 8'h00;
        rst_n = 1'b0; ir = 8'h00; z = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_eq("reset_state", obs, 29'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (ph == 0) begin
                if (didx < 18) begin
                    op = directed[didx];
                    didx++;
                end else begin
                    case ($urandom_range(0, 11))
                        0:       op = 8'hFF;
                        1:       op = 8'($urandom);
                        default: op = 8'($urandom_range(0, 15));
                    endcase
                end
            end
            ir = op;
            z  = 1'($urandom);
            #1 check_eq(ph_name[ph + 1], obs, model_out(ph, op, z));

            do_rst = 1'b0;
            if (ph == 3 && op == 8'h01 && !did_ldac_rst) begin
                do_rst = 1'b1;
                did_ldac_rst = 1'b1;
            end else if (ph == 4 && halt_cnt >= 12) begin
                do_rst = 1'b1;
            end else if (ph >= 0 && ph <= 3 && $urandom_range(0, 39) == 0) begin
                do_rst = 1'b1;
            end

            if (do_rst) begin
                rst_n = 1'b0;
                #1 check_eq("async_reset", obs, 29'd0);
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                ph = -1;
                halt_cnt = 0;
                continue;
            end

            @(posedge clk);
            case (ph)
                -1: ph = 0;
                0:  ph = 1;
                1:  ph = (op == 8'hFF) ? 4 : 2;
                2:  ph = (op == 8'h01 || op == 8'h02) ? 3 : 0;
                3:  ph = 0;
                default: halt_cnt++;
            endcase
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
